mem_bus_arb: RTL and testbench
==============================

# mem_bus_arb

Two-master round-robin arbiter that lets the picorv32 CPU (master 0) and a second bus master such as a loader or debug port (master 1) share one native memory bus (`valid`/`ready`/`wstrb`/`wdata`/`addr`/`rdata`/`instr`). That bus feeds the peripheral decode, including the system-control and timer slaves. The arbiter guarantees one transaction at a time and a mandatory turnaround cycle between transactions. It also provides a bus timeout, so a slave that never asserts ready cannot hang either master.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: number of cycles in a grant state with `s_ready` low before the arbiter aborts the transaction; 0 disables the timeout.
- `TIMEOUT_DATA`, default 32'hFFFF_FFFF: read data returned to the master on timeout.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_valid, m0_instr`  in  1 each  CPU request and instruction-fetch flag.
- `m0_wstrb`  in  4  CPU byte write strobes; 0 means read.
- `m0_wdata, m0_addr`  in  32 each  CPU write data and address.
- `m0_ready`  out  1  CPU transaction complete.
- `m0_rdata`  out  32  CPU read data.
- `m1_valid, m1_instr, m1_wstrb, m1_wdata, m1_addr, m1_ready, m1_rdata`: same directions, widths and meaning as the `m0_*` ports, for master 1.
- `s_valid, s_instr`  out  1 each  request to the shared bus.
- `s_wstrb`  out  4  strobes to the shared bus.
- `s_wdata, s_addr`  out  32 each  data and address to the shared bus.
- `s_ready`  in  1  slave ready.
- `s_rdata`  in  32  slave read data.
- `grant`  out  2  one-hot current owner; 2'b00 when idle.
- `timeout_err`  out  1  sticky; set on any timeout, cleared only by `rst`.

## Operation
- States:
  - IDLE: nothing granted.
  - GNT0: master 0 owns the bus.
  - GNT1: master 1 owns the bus.
- Register `last` records the most recent winner.
- IDLE transitions:
  - Only m0 valid: go to GNT0.
  - Only m1 valid: go to GNT1.
  - Both valid: grant the master that is not `last`.
  - Neither valid: stay in IDLE.
- IDLE updates `last` to the winner when it leaves IDLE.
- In GNTn, the shared bus is driven from master n:
  - `s_valid = mn_valid`.
  - `s_addr`, `s_wdata`, `s_wstrb` and `s_instr` come from master n.
  - `mn_ready = s_ready`.
  - `mn_rdata = s_rdata`.
- Non-owner outputs are held at zero: `ready = 0`, `rdata = 0`. In IDLE, all `s_*` outputs and both `mX_ready` are 0.
- Completion:
  - Condition: in GNTn with `s_ready = 1`.
  - Next state is IDLE; the IDLE cycle is the turnaround.
  - `s_ready` is ignored in IDLE, which absorbs a slave whose registered ready lingers one cycle after valid drops.
- Abandon: in GNTn with `mn_valid = 0` (protocol violation or master reset):
  - Next state is IDLE.
  - No ready is issued.
  - The timeout counter clears.
- Timeout:
  - A counter increments each GNTn cycle where `s_ready = 0`, and clears on entry to IDLE.
  - When the counter reaches `TIMEOUT_CYCLES - 1` and `s_ready` is still 0, that cycle forces `s_valid = 0`, `mn_ready = 1` and `mn_rdata = TIMEOUT_DATA`.
  - In the same cycle it sets `timeout_err`; next state is IDLE.
- Priority within GNTn: `s_ready = 1` takes precedence over the timeout in the same cycle, and the transaction completes normally.
- Requests that arrive while the bus is granted wait; masters hold valid until their ready.
- Width rules:
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
  - The counter saturates and never wraps.
  - `TIMEOUT_CYCLES = 0` removes the compare.

## Timing
- Reset values: state IDLE, `last` = master 1 (so master 0 wins the first tie), `grant` = 0, counter 0, `timeout_err` = 0.
- Outputs during and after reset: all `s_*` and `mX_ready` are 0.
- Grant latency: `mn_valid` first high at cycle t in IDLE gives `grant` and `s_valid` high at t+1.
- `mn_ready` is combinational from `s_ready` in the same cycle.
- Minimum transaction is 3 cycles: request/IDLE, grant with slave ready, turnaround.
- For a registered-ready slave such as system control, the transaction is IDLE, GNT (ready 0), GNT (ready 1), IDLE.
- A request held during the turnaround cycle is granted at the cycle after turnaround.
- Fairness: if both masters request continuously, grants strictly alternate, with one IDLE cycle between grants.
- `rst` asserted mid-transaction: the next cycle returns to reset values; the in-flight transaction is dropped with no ready.

## Test plan
- **m0 read:** m0 read at 0x0200_0000; slave returns `s_ready` 2 cycles after `s_valid` with rdata 0x8000_00A5 -> `m0_rdata` = 0x8000_00A5 with `m0_ready`, `grant` = 01 during the transaction, then one IDLE cycle.
- **Simultaneous requests from reset:** both masters request, slave ready after 1 cycle -> grant order m0, m1, m0, m1; exactly one IDLE cycle between grants; `m1_ready` never high while `grant` = 01.
- **Write pass-through:** m1 write of 0x8000_0000 with `wstrb` 4'hF -> `s_wdata` = 0x8000_0000, `s_wstrb` = F, `s_addr` equal to m1's address; m0 sees `ready` 0 throughout.
- **Timeout:** `TIMEOUT_CYCLES` = 8 and the slave never readies -> on the 8th grant cycle, `m0_ready` = 1, `m0_rdata` = 0xFFFF_FFFF, `s_valid` = 0, and `timeout_err` is 1 from then until `rst`. Variant: `s_ready` asserted on that same cycle -> normal completion and no error.
- **Abandon:** m0 drops valid during GNT0 -> IDLE next cycle, no `m0_ready`, and a pending m1 request is granted 2 cycles later.
- **Reset mid-transaction:** `rst` asserted during GNT1 -> next cycle `grant` = 0 and `s_valid` = 0; then both masters request -> m0 wins.

Source files
------------

// File: rtl/mem_bus_arb.sv
// mem_bus_arb: two-master round-robin arbiter onto one native memory bus, with turnaround and bus timeout
module mem_bus_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m0_addr,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    input  logic [31:0] m1_addr,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    output logic [31:0] s_addr,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = TIMEOUT_CYCLES != 0;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    state_t state_q, state_d;
    logic last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    logic own0, own1, own_valid, timeout, pick1;
    // Bus steering, timeout detection and next-state selection
    always_comb begin
        own0 = state_q == GNT0 && !rst;
        own1 = state_q == GNT1 && !rst;
        own_valid = own1 ? m1_valid : own0 & m0_valid;
        timeout = TO_EN && own_valid && !s_ready && cnt_q == TO_LAST;
        pick1 = m1_valid && (!m0_valid || !last_q);
        grant = {own1, own0};
        s_valid = own_valid && !timeout;
        s_instr = own1 ? m1_instr : own0 & m0_instr;
        s_wstrb = own1 ? m1_wstrb : own0 ? m0_wstrb : 4'h0;
        s_wdata = own1 ? m1_wdata : own0 ? m0_wdata : 32'h0;
        s_addr = own1 ? m1_addr : own0 ? m0_addr : 32'h0;
        m0_ready = own0 && m0_valid && (s_ready || timeout);
        m1_ready = own1 && m1_valid && (s_ready || timeout);
        m0_rdata = own0 ? (timeout ? TIMEOUT_DATA : s_rdata) : 32'h0;
        m1_rdata = own1 ? (timeout ? TIMEOUT_DATA : s_rdata) : 32'h0;
        timeout_err = err_q;
        state_d = state_q;
        last_d = last_q;
        cnt_d = cnt_q;
        err_d = err_q | timeout;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (m0_valid || m1_valid) begin
                state_d = pick1 ? GNT1 : GNT0;
                last_d = pick1;
            end
        end else if (!own_valid || s_ready || timeout) begin
            state_d = IDLE;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q == '1 ? cnt_q : cnt_q + CW'(1);
        end
    end
    // State, round-robin history, timeout counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q <= 1'b1;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_bus_arb.sv
// tb_mem_bus_arb: directed and randomized checks of mem_bus_arb against a transaction-level model
module tb_mem_bus_arb;
    localparam int TO = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic        mv[2], mi[2];
    logic [3:0]  ms[2];
    logic [31:0] md[2], ma[2];
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = 32'h0;
    logic        m0_ready, m1_ready, s_valid, s_instr, timeout_err;
    logic [31:0] m0_rdata, m1_rdata, s_wdata, s_addr;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    int n_chk = 0, n_err = 0;
    int own = 0, last = 2, cnt = 0, age = 0, delay = 0, ab_pm = 0;
    int req_pct[2];
    bit err = 0, rand_rst = 0;
    bit got_rdy[2];
    logic [31:0] rd_val = 32'h0;

    mem_bus_arb #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(mv[0]), .m0_instr(mi[0]), .m0_wstrb(ms[0]), .m0_wdata(md[0]), .m0_addr(ma[0]),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(mv[1]), .m1_instr(mi[1]), .m1_wstrb(ms[1]), .m1_wdata(md[1]), .m1_addr(ma[1]),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_wstrb(s_wstrb), .s_wdata(s_wdata), .s_addr(s_addr),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: slave response, compare against the model, advance the model, then move the masters.
    task automatic tick();
        int o, po;
        logic v, e_to;
        logic e_rdy[2];
        logic [31:0] e_rd[2];
        @(negedge clk);
        s_ready = delay < 0 ? ($urandom_range(2) == 0) : (age >= delay);
        s_rdata = delay < 0 ? $urandom : rd_val;
        #1;
        o = rst ? 0 : own;
        v = o == 0 ? 1'b0 : mv[o-1];
        e_to = v && !s_ready && cnt == TO - 1;
        for (int i = 0; i < 2; i++) begin
            e_rdy[i] = o == i + 1 && v && (s_ready || e_to);
            e_rd[i] = o == i + 1 ? (e_to ? 32'hFFFF_FFFF : s_rdata) : 32'h0;
        end
        chk("grant", 32'(grant), o == 0 ? 32'h0 : 32'(1 << (o - 1)));
        chk("s_valid", 32'(s_valid), 32'(v && !e_to));
        chk("s_addr", s_addr, o == 0 ? 32'h0 : ma[o-1]);
        chk("s_wdata", s_wdata, o == 0 ? 32'h0 : md[o-1]);
        chk("s_wstrb", 32'(s_wstrb), o == 0 ? 32'h0 : 32'(ms[o-1]));
        chk("s_instr", 32'(s_instr), o == 0 ? 32'h0 : 32'(mi[o-1]));
        chk("m0_ready", 32'(m0_ready), 32'(e_rdy[0]));
        chk("m1_ready", 32'(m1_ready), 32'(e_rdy[1]));
        chk("m0_rdata", m0_rdata, e_rd[0]);
        chk("m1_rdata", m1_rdata, e_rd[1]);
        chk("timeout_err", 32'(timeout_err), 32'(err));
        got_rdy[0] = e_rdy[0];
        got_rdy[1] = e_rdy[1];
        @(posedge clk);
        po = own;
        if (rst) begin
            own = 0; last = 2; cnt = 0; err = 0;
        end else if (own == 0) begin
            if (mv[0] && mv[1]) own = 3 - last;
            else if (mv[0]) own = 1;
            else if (mv[1]) own = 2;
            if (own != 0) last = own;
        end else begin
            if (e_to) err = 1;
            if (!v || s_ready || e_to) begin
                own = 0;
                cnt = 0;
            end else cnt++;
        end
        age = (own != 0 && own == po) ? age + 1 : 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!mv[i] || got_rdy[i]) begin
                mv[i] = $urandom_range(99) < req_pct[i];
                if (mv[i]) begin
                    ma[i] = $urandom;
                    md[i] = $urandom;
                    ms[i] = $urandom_range(1) == 1 ? 4'($urandom) : 4'h0;
                    mi[i] = 1'($urandom);
                end
            end else if ($urandom_range(999) < ab_pm) mv[i] = 1'b0;
        end
        if (rand_rst) rst = $urandom_range(299) == 0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        mv = '{1'b0, 1'b0};
        mi = '{1'b0, 1'b0};
        ms = '{4'h0, 4'h0};
        md = '{32'h0, 32'h0};
        ma = '{32'h0, 32'h0};
        req_pct = '{0, 0};
        got_rdy = '{1'b0, 1'b0};
        run(3);
        rst = 1'b0;
        run(2);
        delay = 2; rd_val = 32'h8000_00A5;
        mv[0] = 1'b1; ma[0] = 32'h0200_0000; ms[0] = 4'h0; md[0] = 32'h0; mi[0] = 1'b0;
        run(7);
        rst = 1'b1; run(1); rst = 1'b0;
        delay = 1; req_pct = '{100, 100};
        mv[0] = 1'b1; mv[1] = 1'b1; ma[1] = 32'h0000_1000;
        run(20);
        req_pct = '{0, 0};
        run(8);
        delay = 0;
        mv[1] = 1'b1; ma[1] = 32'h0300_0010; md[1] = 32'h8000_0000; ms[1] = 4'hF; mi[1] = 1'b0;
        run(4);
        delay = 255; rd_val = 32'h1234_5678;
        mv[0] = 1'b1; ma[0] = 32'h0200_0004; ms[0] = 4'h0;
        run(13);
        rst = 1'b1; run(1); rst = 1'b0;
        delay = 7;
        mv[0] = 1'b1; ma[0] = 32'h0200_0008;
        run(12);
        delay = 255;
        mv[0] = 1'b1; ma[0] = 32'h0200_000C;
        run(3);
        mv[1] = 1'b1; ma[1] = 32'h0400_0000; ms[1] = 4'h3; md[1] = 32'hCAFE_F00D;
        run(1);
        mv[0] = 1'b0;
        run(14);
        mv[1] = 1'b1; ma[1] = 32'h0500_0000;
        run(3);
        rst = 1'b1; run(1); rst = 1'b0;
        delay = 0;
        mv[0] = 1'b1; mv[1] = 1'b1;
        run(10);
        delay = -1; req_pct = '{50, 50}; ab_pm = 20; rand_rst = 1;
        run(3000);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
